csa_resolver: RTL and testbench
===============================

CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 The block SHALL have parameter MAX, default 32, giving the width of the carry-save operands and the result.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits added per cycle; MAX SHALL be an integer multiple of CHUNK, and NCH = MAX/CHUNK.
REQ-003 Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_s/in_c carry a valid operand pair.
- in_ready  out  1  block can accept an operand pair.
- in_s  in  MAX  sum vector of a redundant (carry-save) operand.
- in_c  in  MAX  carry vector; already bit-aligned, with in_c[0] as a real weight-1 bit.
- out_valid  out  1  out_sum holds a resolved result.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  MAX  binary result (in_s + in_c) mod 2^MAX.
- out_cout  out  1  carry out of bit MAX-1; present only under CSA_RESOLVER_COUT_EN.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-005 In IDLE: in_ready=1 and out_valid=0; when in_valid=1, the block SHALL register in_s and in_c, clear the chunk index k to 0, clear the running carry to 0, and go to ADD.
REQ-006 In ADD, in each cycle:
- result chunk k SHALL be loaded with the sum of s[k*CHUNK+:CHUNK], c[k*CHUNK+:CHUNK] and the running carry;
- the running carry SHALL be loaded with the carry out of that chunk;
- k SHALL increment by 1.
REQ-007 When ADD completes chunk k=NCH-1, the next state SHALL be DONE.
REQ-008 In ADD, in_ready=0 and out_valid=0; in_valid and input data SHALL be ignored.
REQ-009 In DONE: out_valid=1; out_sum and out_cout SHALL hold stable until out_ready=1; on out_valid and out_ready both 1, the next state SHALL be IDLE.
REQ-010 In DONE, in_ready=0; no new operand is accepted in the handover cycle.
REQ-011 Latency: out_valid SHALL rise exactly NCH cycles after the cycle containing the input handshake.
REQ-012 Throughput SHALL be one result per NCH+2 cycles under a continuously ready consumer.
REQ-013 When NCH=1, ADD SHALL last exactly one cycle.
REQ-014 The carry SHALL propagate across all chunk boundaries, including a ripple through every chunk.
REQ-015 The carry out of the final chunk SHALL be dropped from out_sum (mod 2^MAX).
REQ-016 out_sum SHALL update only in ADD and SHALL keep the last result after returning to IDLE.
REQ-017 out_ready SHALL be ignored outside DONE.

Reset
REQ-018 On rst_n=0, the block SHALL asynchronously enter IDLE with:
- out_sum = 0, out_cout = 0, out_valid = 0;
- k = 0 and running carry = 0;
- in_ready = 1 from the first cycle after deassertion.
REQ-019 Reset during ADD or DONE SHALL discard the operation in progress with no partial output.

Configuration
REQ-020 The macro CSA_RESOLVER_COUT_EN SHALL control the carry-out output.
- Defined: out_cout exists; it SHALL be loaded with the final-chunk carry at the ADD->DONE transition and held with out_sum.
- Undefined: the port and its register are absent; function is otherwise identical.

Verification (MAX=32, CHUNK=8 unless stated)
REQ-021 Operands s=0x000000FF, c=0x00000001 -> out_sum=0x00000100, out_cout=0, out_valid 4 cycles after the handshake.
REQ-022 Operands s=0xFFFFFFFF, c=0x00000001 -> out_sum=0x00000000, out_cout=1 (with the macro), carry ripples through all 4 chunks.
REQ-023 Result s=0x12345678 + c=0x11111111 with out_ready held low 5 cycles -> out_sum=0x23456789 held stable with out_valid=1 throughout; IDLE entered the cycle after out_ready rises.
REQ-024 in_valid asserted with different data during ADD -> ignored, in_ready=0, and the result reflects only the first operand pair.
REQ-025 rst_n pulsed low during ADD at k=2 -> out_valid=0, out_sum=0, in_ready=1 after reset, and the next operand resolves correctly.
REQ-026 CHUNK=32 with s=0x80000000, c=0x80000000 -> out_sum=0, out_cout=1, out_valid 1 cycle after the handshake.

Source files
------------

// File: rtl/csa_resolver.sv
// Sequential resolver: converts a carry-save operand pair into binary, CHUNK bits per cycle.
// Optional out_cout port enabled by defining CSA_RESOLVER_COUT_EN.
module csa_resolver #(
    parameter int MAX   = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [MAX-1:0] in_s,
    input  logic [MAX-1:0] in_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MAX-1:0] out_sum
`ifdef CSA_RESOLVER_COUT_EN
    ,
    output logic           out_cout
`endif
);

    localparam int NCH = MAX / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [MAX-1:0]   s_reg;
    logic [MAX-1:0]   c_reg;
    logic [KW-1:0]    k;
    logic             carry;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK-1:0] c_chunk;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        s_chunk   = s_reg[k*CHUNK +: CHUNK];
        c_chunk   = c_reg[k*CHUNK +: CHUNK];
        chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, carry};
    end

    // in_ready/out_valid are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s_reg     <= '0;
            c_reg     <= '0;
            k         <= '0;
            carry     <= 1'b0;
            out_sum   <= '0;
`ifdef CSA_RESOLVER_COUT_EN
            out_cout  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_reg    <= in_s;
                        c_reg    <= in_c;
                        k        <= '0;
                        carry    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    out_sum[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry <= chunk_sum[CHUNK];
                    k     <= k + 1'b1;
                    // Final chunk's carry leaves out_sum (mod 2^MAX) and optionally feeds out_cout.
                    if (k == LAST_K) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef CSA_RESOLVER_COUT_EN
                        out_cout  <= chunk_sum[CHUNK];
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed self-checking bench for csa_resolver (CHUNK=8 instance plus a single-chunk instance).
module tb_csa_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_s, in_c, out_sum;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_s1, in_c1, out_sum1;
`ifdef CSA_RESOLVER_COUT_EN
    logic        out_cout, out_cout1;
`endif
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa_resolver #(.MAX(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum)
`ifdef CSA_RESOLVER_COUT_EN
        , .out_cout(out_cout)
`endif
    );

    csa_resolver #(.MAX(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_s(in_s1), .in_c(in_c1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1)
`ifdef CSA_RESOLVER_COUT_EN
        , .out_cout(out_cout1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [31:0] s, input logic [31:0] c, input string nm);
        in_s = s; in_c = c; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s_in_ready got=%b exp=1", nm, in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; out_ready = 0; in_s = '0; in_c = '0;
        in_valid1 = 0; out_ready1 = 0; in_s1 = '0; in_c1 = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 32'h0) begin
            failures++; $display("FAIL reset_out got valid=%b sum=%h exp valid=0 sum=0", out_valid, out_sum);
        end
`ifdef CSA_RESOLVER_COUT_EN
        checks++;
        if (out_cout !== 1'b0) begin
            failures++; $display("FAIL reset_cout got=%b exp=0", out_cout);
        end
`endif
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_idle got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    // s + c with carry out of chunk 0, checks exact 4-cycle latency and result retention in IDLE
    task automatic test_basic();
        out_ready = 1'b1;
        handshake(32'h0000_00FF, 32'h0000_0001, "basic");
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (out_valid !== (i == 4)) begin
                failures++; $display("FAIL basic_latency cycle=%0d got=%b exp=%b", i, out_valid, (i == 4));
            end
        end
        checks++;
        if (out_sum !== 32'h0000_0100 || in_ready !== 1'b0) begin
            failures++; $display("FAIL basic_sum got sum=%h ready=%b exp sum=00000100 ready=0", out_sum, in_ready);
        end
`ifdef CSA_RESOLVER_COUT_EN
        checks++;
        if (out_cout !== 1'b0) begin
            failures++; $display("FAIL basic_cout got=%b exp=0", out_cout);
        end
`endif
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'h0000_0100) begin
            failures++; $display("FAIL basic_retain got ready=%b valid=%b sum=%h exp 1 0 00000100", in_ready, out_valid, out_sum);
        end
    endtask

    task automatic test_ripple();
        out_ready = 1'b1;
        handshake(32'hFFFF_FFFF, 32'h0000_0001, "ripple");
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h0) begin
            failures++; $display("FAIL ripple_sum got valid=%b sum=%h exp valid=1 sum=00000000", out_valid, out_sum);
        end
`ifdef CSA_RESOLVER_COUT_EN
        checks++;
        if (out_cout !== 1'b1) begin
            failures++; $display("FAIL ripple_cout got=%b exp=1", out_cout);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        handshake(32'h1234_5678, 32'h1111_1111, "bp");
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 32'h2345_6789 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold cycle=%0d got valid=%b sum=%h ready=%b exp 1 23456789 0",
                                     i, out_valid, out_sum, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_still_valid got=%b exp=1", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_ignore_in_add();
        out_ready = 1'b1;
        handshake(32'h0F0F_0F0F, 32'h0101_0101, "ign");
        in_valid = 1'b1; in_s = 32'hDEAD_BEEF; in_c = 32'h1357_9BDF;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL ign_ready cycle=%0d got=%b exp=0", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h1010_1010) begin
            failures++; $display("FAIL ign_sum got valid=%b sum=%h exp valid=1 sum=10101010", out_valid, out_sum);
        end
        tick();
    endtask

    task automatic test_reset_mid_add();
        out_ready = 1'b1;
        handshake(32'hAAAA_AAAA, 32'h5555_5555, "rst");
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 32'h0) begin
            failures++; $display("FAIL rst_async got valid=%b sum=%h exp valid=0 sum=0", out_valid, out_sum);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'h0) begin
            failures++; $display("FAIL rst_after got ready=%b valid=%b sum=%h exp 1 0 0", in_ready, out_valid, out_sum);
        end
        handshake(32'h0000_0001, 32'h0000_0002, "rst2");
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h0000_0003) begin
            failures++; $display("FAIL rst_next got valid=%b sum=%h exp valid=1 sum=00000003", out_valid, out_sum);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int rises[$];
        out_ready = 1'b1; in_valid = 1'b1; in_s = 32'h0000_8000; in_c = 32'h0000_8000;
        while (rises.size() < 2 && cyc < 40) begin
            tick();
            cyc++;
            if (out_valid === 1'b1) rises.push_back(cyc);
        end
        in_valid = 1'b0;
        checks++;
        if (rises.size() != 2) begin
            failures++; $display("FAIL b2b_timeout got=%0d results exp=2", rises.size());
        end else begin
            checks++;
            if (rises[1] - rises[0] != 6) begin
                failures++; $display("FAIL b2b_period got=%0d exp=6", rises[1] - rises[0]);
            end
        end
        checks++;
        if (out_sum !== 32'h0001_0000) begin
            failures++; $display("FAIL b2b_sum got=%h exp=00010000", out_sum);
        end
        tick();
    endtask

    task automatic test_single_chunk();
        out_ready1 = 1'b1; in_s1 = 32'h8000_0000; in_c1 = 32'h8000_0000; in_valid1 = 1'b1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            failures++; $display("FAIL c32_ready got=%b exp=1", in_ready1);
        end
        tick();
        in_valid1 = 1'b0;
        tick();
        checks++;
        if (out_valid1 !== 1'b1 || out_sum1 !== 32'h0) begin
            failures++; $display("FAIL c32_result got valid=%b sum=%h exp valid=1 sum=0", out_valid1, out_sum1);
        end
`ifdef CSA_RESOLVER_COUT_EN
        checks++;
        if (out_cout1 !== 1'b1) begin
            failures++; $display("FAIL c32_cout got=%b exp=1", out_cout1);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_ignore_in_add();
        test_reset_mid_add();
        test_back_to_back();
        test_single_chunk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
